// File: rtl/i2c_accel_responder_if.sv
// Pin-level I2C bundle between a bus master (or bench) and the accelerometer responder.
// SDA is open-drain: sda_oe=1 pulls the line low, otherwise the pad is released.
interface i2c_accel_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_accel_responder.sv
// I2C target emulating the MPU6050 register view: serves a fabric-supplied Z acceleration,
// WHO_AM_I and PWR_MGMT_1, and reports every written data byte to the fabric.
module i2c_accel_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter logic [7:0] WHOAMI_VAL = 8'h68,
    parameter logic [7:0] PWR_RST    = 8'h40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    i2c_accel_responder_if.slave        bus,
    input  logic [15:0]                 i_accel_z,
    output logic                        o_sleep,
    output logic                        o_wr_stb,
    output logic [7:0]                  o_wr_reg,
    output logic [7:0]                  o_wr_data,
    output logic                        o_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_IGNORE
    } state_t;

    state_t      r_state, w_state_next;

    logic        r_scl_s1, r_scl_s2, r_scl_prev;
    logic        r_sda_s1, r_sda_s2, r_sda_prev;

    logic [3:0]  r_bit_cnt, w_cnt_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [7:0]  r_ptr, w_ptr_next;
    logic [15:0] r_snap, w_snap_next;
    logic        r_rw, w_rw_next;
    logic [7:0]  r_pwr, w_pwr_next;
    logic        r_sda_oe, w_sda_oe_next;
    logic        r_busy, w_busy_next;
    logic        r_wr_stb, w_wr_stb_next;
    logic [7:0]  r_wr_reg, w_wr_reg_next;
    logic [7:0]  r_wr_data, w_wr_data_next;

    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte_in;
    logic [7:0]  w_rd_byte;
    logic [2:0]  w_rd_idx;

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= bus.scl_in;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= bus.sda_in;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
    assign w_byte_in  = {r_shift[6:0], r_sda_s2};
    assign w_rd_idx   = 3'd7 - r_bit_cnt[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_snap    <= 16'h0000;
            r_rw      <= 1'b0;
            r_pwr     <= PWR_RST;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_reg  <= 8'h00;
            r_wr_data <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_ptr     <= w_ptr_next;
            r_snap    <= w_snap_next;
            r_rw      <= w_rw_next;
            r_pwr     <= w_pwr_next;
            r_sda_oe  <= w_sda_oe_next;
            r_busy    <= w_busy_next;
            r_wr_stb  <= w_wr_stb_next;
            r_wr_reg  <= w_wr_reg_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_bit_cnt;
        w_shift_next   = r_shift;
        w_ptr_next     = r_ptr;
        w_snap_next    = r_snap;
        w_rw_next      = r_rw;
        w_pwr_next     = r_pwr;
        w_sda_oe_next  = r_sda_oe;
        w_busy_next    = r_busy;
        w_wr_stb_next  = 1'b0;
        w_wr_reg_next  = r_wr_reg;
        w_wr_data_next = r_wr_data;

        if (w_start) begin
            w_state_next  = S_ADDR;
            w_cnt_next    = 4'd0;
            w_sda_oe_next = 1'b0;
            w_busy_next   = 1'b0;
        end else if (w_stop) begin
            w_state_next  = S_IDLE;
            w_cnt_next    = 4'd0;
            w_sda_oe_next = 1'b0;
            w_busy_next   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte_in;
                        w_cnt_next   = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_cnt_next = 4'd0;
                            if (w_byte_in[7:1] == DEV_ADDR) begin
                                w_state_next = S_ADDR_ACK;
                                w_busy_next  = 1'b1;
                                w_rw_next    = w_byte_in[0];
                                // One snapshot per read transaction keeps the H/L pair coherent.
                                if (w_byte_in[0]) begin
                                    w_snap_next = i_accel_z;
                                end
                            end else begin
                                w_state_next = S_IGNORE;
                            end
                        end
                    end
                end

                S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte_in;
                        w_cnt_next   = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_cnt_next = 4'd0;
                            if (r_state == S_REG) begin
                                w_ptr_next   = w_byte_in;
                                w_state_next = S_REG_ACK;
                            end else begin
                                w_state_next = S_WDATA_ACK;
                            end
                        end
                    end
                end

                // Bit counter 0 = waiting for the fall that opens the ACK slot, 1 = ACK driven.
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_sda_oe_next = 1'b1;
                            w_cnt_next    = 4'd1;
                        end else begin
                            w_sda_oe_next = 1'b0;
                            w_cnt_next    = 4'd0;
                            if (r_state == S_ADDR_ACK) begin
                                if (r_rw) begin
                                    w_state_next  = S_RDATA;
                                    w_sda_oe_next = ~w_rd_byte[7];
                                    w_cnt_next    = 4'd1;
                                end else begin
                                    w_state_next = S_REG;
                                end
                            end else if (r_state == S_REG_ACK) begin
                                w_state_next = S_WDATA;
                            end else begin
                                w_state_next   = S_WDATA;
                                w_wr_stb_next  = 1'b1;
                                w_wr_reg_next  = r_ptr;
                                w_wr_data_next = r_shift;
                                if (r_ptr == 8'h6B) begin
                                    w_pwr_next = r_shift;
                                end
                                w_ptr_next = r_ptr + 8'd1;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_next = 1'b0;
                            w_cnt_next    = 4'd0;
                            w_state_next  = S_RACK;
                        end else begin
                            w_sda_oe_next = ~w_rd_byte[w_rd_idx];
                            w_cnt_next    = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_RACK: begin
                    if (w_scl_rise) begin
                        if (!r_sda_s2) begin
                            w_ptr_next   = r_ptr + 8'd1;
                            w_cnt_next   = 4'd0;
                            w_state_next = S_RDATA;
                        end else begin
                            w_state_next = S_IGNORE;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (r_ptr)
            8'h3F:   w_rd_byte = r_snap[15:8];
            8'h40:   w_rd_byte = r_snap[7:0];
            8'h6B:   w_rd_byte = r_pwr;
            8'h75:   w_rd_byte = WHOAMI_VAL;
            default: w_rd_byte = 8'h00;
        endcase
        bus.sda_oe = r_sda_oe;
        o_sleep    = r_pwr[6];
        o_wr_stb   = r_wr_stb;
        o_wr_reg   = r_wr_reg;
        o_wr_data  = r_wr_data;
        o_busy     = r_busy;
    end

endmodule

// File: tb/tb_i2c_accel_responder.sv
// Bench for i2c_accel_responder: a bit-banged I2C master drives directed and random
// transactions and checks read data, ACKs and write strobes against a register-map model.
`timescale 1ns/1ps
module tb_i2c_accel_responder;

   localparam int Q = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mScl;
   logic        mSda;
   logic [15:0] accelZ;
   logic        dutSleep;
   logic        dutWrStb;
   logic [7:0]  dutWrReg;
   logic [7:0]  dutWrData;
   logic        dutBusy;

   int nCompared = 0;
   int nMismatched = 0;

   logic [7:0] modelPtr = 8'h00;
   logic [7:0] modelPwr = 8'h40;

   logic [7:0] stbRegQ[$];
   logic [7:0] stbDataQ[$];
   logic       stbSleepQ[$];
   int         oeCount = 0;
   int         busyCount = 0;

   i2c_accel_responder_if bus();

   assign bus.scl_in = mScl;
   assign bus.sda_in = mSda & ~bus.sda_oe;

   i2c_accel_responder #(
      .DEV_ADDR(7'h68),
      .WHOAMI_VAL(8'h68),
      .PWR_RST(8'h40)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .i_accel_z(accelZ),
      .o_sleep(dutSleep),
      .o_wr_stb(dutWrStb),
      .o_wr_reg(dutWrReg),
      .o_wr_data(dutWrData),
      .o_busy(dutBusy)
   );

   always #5 clk = ~clk;

   // Observers run on the falling clock edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (dutWrStb === 1'b1) begin
         stbRegQ.push_back(dutWrReg);
         stbDataQ.push_back(dutWrData);
         stbSleepQ.push_back(dutSleep);
      end
      if (bus.sda_oe === 1'b1) oeCount++;
      if (dutBusy === 1'b1) busyCount++;
   end

   initial begin
      #(5_000_000);
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Register map as seen by a reader: snapshot bytes, power register, identity, zeros elsewhere.
   function automatic logic [7:0] modelReg(input logic [7:0] addr, input logic [15:0] z,
                                            input logic [7:0] pwr);
      if (addr == 8'h3F) return z[15:8];
      if (addr == 8'h40) return z[7:0];
      if (addr == 8'h6B) return pwr;
      if (addr == 8'h75) return 8'h68;
      return 8'h00;
   endfunction

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic busStart();
      if (mScl == 1'b0) begin
         mSda = 1'b1;
         waitClk(Q);
         mScl = 1'b1;
         waitClk(Q);
      end
      mSda = 1'b0;
      waitClk(2 * Q);
      mScl = 1'b0;
      waitClk(Q);
   endtask

   task automatic busStop();
      mSda = 1'b0;
      waitClk(Q);
      mScl = 1'b1;
      waitClk(2 * Q);
      mSda = 1'b1;
      waitClk(2 * Q);
   endtask

   task automatic sendBit(input logic b);
      mSda = b;
      waitClk(Q);
      mScl = 1'b1;
      waitClk(2 * Q);
      mScl = 1'b0;
      waitClk(Q);
   endtask

   task automatic recvBit(output logic b);
      mSda = 1'b1;
      waitClk(Q);
      mScl = 1'b1;
      waitClk(Q);
      b = bus.sda_in;
      waitClk(Q);
      mScl = 1'b0;
      waitClk(Q);
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      logic line;
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
      recvBit(line);
      ack = ~line;
   endtask

   task automatic readByte(output logic [7:0] d, input logic last);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         recvBit(bit_v);
         d[i] = bit_v;
      end
      sendBit(last);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mScl = 1'b1;
      mSda = 1'b1;
      accelZ = 16'h0000;
      waitClk(5);
      nCompared++;
      if (bus.sda_oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
      nCompared++;
      if (dutSleep !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_sleep: got %b expected 1", dutSleep); end
      nCompared++;
      if (dutBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", dutBusy); end
      nCompared++;
      if (dutWrStb !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wr_stb: got %b expected 0", dutWrStb); end
      nCompared++;
      if (dutWrReg !== 8'h00 || dutWrData !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL reset_wr_regs: got %02h/%02h expected 00/00", dutWrReg, dutWrData);
      end
      rst_n = 1'b1;
      waitClk(4 * Q);
      modelPtr = 8'h00;
      modelPwr = 8'h40;
   endtask

   task automatic test_whoami();
      logic ack;
      logic [7:0] got;
      busStart();
      writeByte(8'hD0, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL whoami_ack_addr_w: got %b expected 1", ack); end
      writeByte(8'h75, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL whoami_ack_reg: got %b expected 1", ack); end
      busStart();
      writeByte(8'hD1, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL whoami_ack_addr_r: got %b expected 1", ack); end
      nCompared++;
      if (dutBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL whoami_busy_during: got %b expected 1", dutBusy); end
      readByte(got, 1'b1);
      nCompared++;
      if (got !== 8'h68) begin nMismatched++; $display("[TB] FAIL whoami_data: got %02h expected 68", got); end
      busStop();
      nCompared++;
      if (dutBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL whoami_busy_after_stop: got %b expected 0", dutBusy); end
      modelPtr = 8'h75;
   endtask

   task automatic test_burst_z();
      logic ack;
      logic [7:0] got;
      accelZ = 16'hF3A2;
      busStart();
      writeByte(8'hD0, ack);
      writeByte(8'h3F, ack);
      busStart();
      writeByte(8'hD1, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL burst_z_ack: got %b expected 1", ack); end
      accelZ = 16'h1234;
      readByte(got, 1'b0);
      nCompared++;
      if (got !== 8'hF3) begin nMismatched++; $display("[TB] FAIL burst_z_high: got %02h expected f3", got); end
      readByte(got, 1'b1);
      nCompared++;
      if (got !== 8'hA2) begin nMismatched++; $display("[TB] FAIL burst_z_low: got %02h expected a2", got); end
      busStop();
      modelPtr = 8'h40;
   endtask

   task automatic test_write_pwr();
      logic ack;
      logic [7:0] got;
      int base;
      base = stbRegQ.size();
      busStart();
      writeByte(8'hD0, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL pwr_ack_addr: got %b expected 1", ack); end
      writeByte(8'h6B, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL pwr_ack_reg: got %b expected 1", ack); end
      writeByte(8'h00, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL pwr_ack_data: got %b expected 1", ack); end
      busStop();
      nCompared++;
      if (stbRegQ.size() !== base + 1) begin
         nMismatched++;
         $display("[TB] FAIL pwr_stb_count: got %0d expected %0d", stbRegQ.size() - base, 1);
      end
      nCompared++;
      if (stbRegQ[base] !== 8'h6B || stbDataQ[base] !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL pwr_stb_fields: got %02h/%02h expected 6b/00", stbRegQ[base], stbDataQ[base]);
      end
      nCompared++;
      if (stbSleepQ[base] !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL pwr_sleep_with_stb: got %b expected 0", stbSleepQ[base]);
      end
      nCompared++;
      if (dutSleep !== 1'b0) begin nMismatched++; $display("[TB] FAIL pwr_sleep: got %b expected 0", dutSleep); end
      modelPwr = 8'h00;
      busStart();
      writeByte(8'hD0, ack);
      writeByte(8'h6B, ack);
      busStart();
      writeByte(8'hD1, ack);
      readByte(got, 1'b1);
      busStop();
      nCompared++;
      if (got !== modelReg(8'h6B, accelZ, modelPwr)) begin
         nMismatched++;
         $display("[TB] FAIL pwr_readback: got %02h expected %02h", got, modelReg(8'h6B, accelZ, modelPwr));
      end
      modelPtr = 8'h6B;
   endtask

   task automatic test_wrong_addr();
      logic ack;
      int oe0, busy0, stb0;
      oe0 = oeCount;
      busy0 = busyCount;
      stb0 = stbRegQ.size();
      busStart();
      writeByte(8'hA0, ack);
      nCompared++;
      if (ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrong_addr_ack: got %b expected 0", ack); end
      writeByte(8'h6B, ack);
      writeByte(8'h55, ack);
      busStop();
      nCompared++;
      if (oeCount !== oe0) begin nMismatched++; $display("[TB] FAIL wrong_addr_sda_oe: got %0d driven cycles expected 0", oeCount - oe0); end
      nCompared++;
      if (busyCount !== busy0) begin nMismatched++; $display("[TB] FAIL wrong_addr_busy: got %0d busy cycles expected 0", busyCount - busy0); end
      nCompared++;
      if (stbRegQ.size() !== stb0) begin nMismatched++; $display("[TB] FAIL wrong_addr_stb: got %0d pulses expected 0", stbRegQ.size() - stb0); end
   endtask

   task automatic test_ptr_wrap();
      logic ack;
      int base;
      base = stbRegQ.size();
      busStart();
      writeByte(8'hD0, ack);
      writeByte(8'hFF, ack);
      writeByte(8'h11, ack);
      writeByte(8'h22, ack);
      nCompared++;
      if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrap_ack: got %b expected 1", ack); end
      busStop();
      nCompared++;
      if (stbRegQ.size() !== base + 2) begin
         nMismatched++;
         $display("[TB] FAIL wrap_stb_count: got %0d expected 2", stbRegQ.size() - base);
      end
      nCompared++;
      if (stbRegQ[base] !== 8'hFF || stbDataQ[base] !== 8'h11) begin
         nMismatched++;
         $display("[TB] FAIL wrap_first: got %02h/%02h expected ff/11", stbRegQ[base], stbDataQ[base]);
      end
      nCompared++;
      if (stbRegQ[base + 1] !== 8'h00 || stbDataQ[base + 1] !== 8'h22) begin
         nMismatched++;
         $display("[TB] FAIL wrap_second: got %02h/%02h expected 00/22", stbRegQ[base + 1], stbDataQ[base + 1]);
      end
      modelPtr = 8'h01;
   endtask

   task automatic test_random();
      logic ack;
      logic [7:0] got, exp, addr, data;
      logic [7:0] expReg[3];
      logic [7:0] expData[3];
      int kind, n, base;
      for (int t = 0; t < 14; t++) begin
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 3);
         case ($urandom_range(0, 4))
            0: addr = 8'h3F;
            1: addr = 8'h40;
            2: addr = 8'h6B;
            3: addr = 8'h75;
            default: addr = 8'($urandom);
         endcase
         if (kind == 0) begin
            base = stbRegQ.size();
            busStart();
            writeByte(8'hD0, ack);
            writeByte(addr, ack);
            nCompared++;
            if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL rand_wr_reg_ack: got %b expected 1", ack); end
            modelPtr = addr;
            for (int i = 0; i < n; i++) begin
               data = 8'($urandom);
               writeByte(data, ack);
               nCompared++;
               if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL rand_wr_data_ack: got %b expected 1", ack); end
               expReg[i] = modelPtr;
               expData[i] = data;
               if (modelPtr == 8'h6B) modelPwr = data;
               modelPtr = modelPtr + 8'd1;
            end
            busStop();
            nCompared++;
            if (stbRegQ.size() !== base + n) begin
               nMismatched++;
               $display("[TB] FAIL rand_stb_count: got %0d expected %0d", stbRegQ.size() - base, n);
            end
            for (int i = 0; i < n; i++) begin
               nCompared++;
               if (stbRegQ[base + i] !== expReg[i] || stbDataQ[base + i] !== expData[i]) begin
                  nMismatched++;
                  $display("[TB] FAIL rand_stb_fields: got %02h/%02h expected %02h/%02h",
                           stbRegQ[base + i], stbDataQ[base + i], expReg[i], expData[i]);
               end
            end
            nCompared++;
            if (dutSleep !== modelPwr[6]) begin nMismatched++; $display("[TB] FAIL rand_sleep: got %b expected %b", dutSleep, modelPwr[6]); end
         end else begin
            accelZ = 16'($urandom);
            busStart();
            if (kind == 1) begin
               writeByte(8'hD0, ack);
               writeByte(addr, ack);
               modelPtr = addr;
               busStart();
            end
            writeByte(8'hD1, ack);
            nCompared++;
            if (ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL rand_rd_addr_ack: got %b expected 1", ack); end
            for (int i = 0; i < n; i++) begin
               exp = modelReg(modelPtr, accelZ, modelPwr);
               readByte(got, (i == n - 1));
               nCompared++;
               if (got !== exp) begin
                  nMismatched++;
                  $display("[TB] FAIL rand_rd_data: got %02h expected %02h at reg %02h", got, exp, modelPtr);
               end
               if (i != n - 1) modelPtr = modelPtr + 8'd1;
            end
            busStop();
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ack;
      logic [7:0] got;
      busStart();
      for (int i = 7; i >= 0; i--) sendBit(bit'(8'hD0 >> i));
      nCompared++;
      if (bus.sda_oe !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_ack_driven: got %b expected 1", bus.sda_oe); end
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (bus.sda_oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_release: got %b expected 0", bus.sda_oe); end
      nCompared++;
      if (dutBusy !== 1'b0 || dutSleep !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset_flags: got busy=%b sleep=%b expected busy=0 sleep=1", dutBusy, dutSleep);
      end
      nCompared++;
      if (dutWrReg !== 8'h00 || dutWrData !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset_wr_regs: got %02h/%02h expected 00/00", dutWrReg, dutWrData);
      end
      mSda = 1'b1;
      waitClk(Q);
      mScl = 1'b1;
      waitClk(4 * Q);
      rst_n = 1'b1;
      waitClk(4 * Q);
      modelPtr = 8'h00;
      modelPwr = 8'h40;
      busStart();
      writeByte(8'hD1, ack);
      readByte(got, 1'b1);
      busStop();
      nCompared++;
      if (got !== modelReg(modelPtr, accelZ, modelPwr)) begin
         nMismatched++;
         $display("[TB] FAIL mid_ptr_cleared: got %02h expected %02h", got, modelReg(modelPtr, accelZ, modelPwr));
      end
      busStart();
      writeByte(8'hD0, ack);
      writeByte(8'h6B, ack);
      busStart();
      writeByte(8'hD1, ack);
      readByte(got, 1'b1);
      busStop();
      nCompared++;
      if (got !== modelReg(8'h6B, accelZ, modelPwr)) begin
         nMismatched++;
         $display("[TB] FAIL mid_pwr_restored: got %02h expected %02h", got, modelReg(8'h6B, accelZ, modelPwr));
      end
   endtask

   initial begin
      $display("[TB] starting i2c_accel_responder bench");
      test_reset();
      test_whoami();
      test_burst_z();
      test_write_pwr();
      test_wrong_addr();
      test_ptr_wrap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
